// File: rtl/mutex_pkg.sv
// Shared types, constants and helpers for the mutex subsystem checker arbiter.
package mutex_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned MAX_REQ    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // One-hot vector with bit idx set, sized for the largest supported requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/sign_check_arbiter_if.sv
// Requester bus plus the link to the shared sign checker.
interface sign_check_arbiter_if
    import mutex_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    rsp_pos;
    logic                    rsp_neg;
    logic                    busy;
    logic [DATA_W-1:0]       chk_in;
    logic                    chk_pos;
    logic                    chk_neg;

    // Client/checker side of the bus.
    modport master (
        output req, req_data, chk_pos, chk_neg,
        input  gnt, done, rsp_pos, rsp_neg, busy, chk_in
    );

    // Arbiter side of the bus.
    modport slave (
        input  req, req_data, chk_pos, chk_neg,
        output gnt, done, rsp_pos, rsp_neg, busy, chk_in
    );

endinterface

// File: rtl/sign_check_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] win_o
);

    int unsigned cand;

    // Scan N_REQ positions starting at the pointer; first hit wins.
    always_comb begin
        valid_o = 1'b0;
        win_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o = 1'b1;
                win_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sign_check_arbiter.sv
// Round-robin arbiter sharing one sign-classification checker between N_REQ clients.
module sign_check_arbiter
    import mutex_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CHK_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sign_check_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]  chk_in_q, chk_in_d;
    logic               rsp_pos_q, rsp_pos_d;
    logic               rsp_neg_q, rsp_neg_d;
    logic               busy_q;

    logic [N_REQ-1:0]   pick_req;
    logic [IDX_W-1:0]   pick_ptr;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_win;
    logic [IDX_W-1:0]   ptr_inc;

    assign ptr_inc = (32'(win_q) == N_REQ - 1) ? '0 : win_q + IDX_W'(1);

    // Arbitration input: fresh scan from IDLE, or current winner excluded when leaving RESP.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (state_q == RESP) begin
            pick_req = bus.req & ~gnt_q;
            pick_ptr = ptr_inc;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    // Next-state and register-input logic for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        chk_in_d  = chk_in_q;
        rsp_pos_d = rsp_pos_q;
        rsp_neg_d = rsp_neg_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = ISSUE;
                    win_d    = pick_win;
                    gnt_d    = N_REQ'(onehot(32'(pick_win)));
                    chk_in_d = bus.req_data[32'(pick_win)*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(CHK_LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    rsp_pos_d = bus.chk_pos;
                    rsp_neg_d = bus.chk_neg;
                    done_d    = gnt_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                ptr_d = ptr_inc;
                if (pick_valid) begin
                    state_d  = ISSUE;
                    win_d    = pick_win;
                    gnt_d    = N_REQ'(onehot(32'(pick_win)));
                    chk_in_d = bus.req_data[32'(pick_win)*DATA_W +: DATA_W];
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            chk_in_q  <= '0;
            rsp_pos_q <= 1'b0;
            rsp_neg_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            chk_in_q  <= chk_in_d;
            rsp_pos_q <= rsp_pos_d;
            rsp_neg_q <= rsp_neg_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.chk_in  = chk_in_q;
    assign bus.rsp_pos = rsp_pos_q;
    assign bus.rsp_neg = rsp_neg_q;
    assign bus.busy    = busy_q;

endmodule
